// File: rtl/scan_seq_ctrl.sv
// scan_seq_ctrl: configuration latch and x/y scan sequencer for the 2D
// strided address generator. Addresses are built incrementally: a row base
// accumulates y_stride and the presented address accumulates x_stride. This
// matches offset + x*x_stride + y*y_stride modulo 2^WIDTH.
module scan_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_offset,
  input  logic [WIDTH-1:0] cfg_x_max,
  input  logic [WIDTH-1:0] cfg_x_stride,
  input  logic [WIDTH-1:0] cfg_y_max,
  input  logic [WIDTH-1:0] cfg_y_stride,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output logic             addr_valid,
  input  logic             addr_ready,
  output logic [WIDTH-1:0] addr,
  output logic             addr_last
);

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO = '0;

  typedef enum logic [1:0] {IDLE, LOADED, RUN, DONE} state_t;

  state_t state;

  // Staged configuration, written by the cfg port while not running.
  logic [WIDTH-1:0] c_offset, c_xm, c_xs, c_ym, c_ys;
  // Working copy for the active job. A config written in the same cycle as
  // start therefore cannot disturb the job being launched.
  logic [WIDTH-1:0] r_xm, r_xs, r_ym, r_ys;
  // Position of the presented address, and the base of its row.
  logic [WIDTH-1:0] x, y, row;

  // Sequencer FSM with registered outputs and the single output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      cfg_err    <= 1'b0;
      cfg_ready  <= 1'b1;
      addr_valid <= 1'b0;
      addr_last  <= 1'b0;
      addr       <= ZERO;
      c_offset   <= ZERO;
      c_xm       <= ZERO;
      c_xs       <= ZERO;
      c_ym       <= ZERO;
      c_ys       <= ZERO;
      r_xm       <= ZERO;
      r_xs       <= ZERO;
      r_ym       <= ZERO;
      r_ys       <= ZERO;
      x          <= ZERO;
      y          <= ZERO;
      row        <= ZERO;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      case (state)
        IDLE, LOADED: begin
          if (cfg_valid) begin
            c_offset <= cfg_offset;
            c_xm     <= cfg_x_max;
            c_xs     <= cfg_x_stride;
            c_ym     <= cfg_y_max;
            c_ys     <= cfg_y_stride;
            state    <= LOADED;
          end
          // start reads the pre-edge config, so a same-cycle write only
          // affects the next job.
          if (start) begin
            if (state == IDLE || c_xm == ZERO || c_ym == ZERO) begin
              cfg_err <= 1'b1;
            end else begin
              r_xm       <= c_xm;
              r_xs       <= c_xs;
              r_ym       <= c_ym;
              r_ys       <= c_ys;
              x          <= ZERO;
              y          <= ZERO;
              row        <= c_offset;
              addr       <= c_offset;
              addr_valid <= 1'b1;
              addr_last  <= (c_xm == ONE) && (c_ym == ONE);
              busy       <= 1'b1;
              cfg_ready  <= 1'b0;
              state      <= RUN;
            end
          end
        end
        RUN: begin
          if (abort) begin
            addr_valid <= 1'b0;
            addr_last  <= 1'b0;
            busy       <= 1'b0;
            cfg_ready  <= 1'b1;
            state      <= LOADED;
          end else if (addr_ready) begin
            if (addr_last) begin
              addr_valid <= 1'b0;
              addr_last  <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
              state      <= DONE;
            end else if (x == r_xm - ONE) begin
              // Row wrap. Equality compares keep x_max = 2^WIDTH-1 legal.
              x         <= ZERO;
              y         <= y + ONE;
              row       <= row + r_ys;
              addr      <= row + r_ys;
              addr_last <= (r_xm == ONE) && (y + ONE == r_ym - ONE);
            end else begin
              x         <= x + ONE;
              addr      <= addr + r_xs;
              addr_last <= (x + ONE == r_xm - ONE) && (y == r_ym - ONE);
            end
          end
        end
        DONE: begin
          state     <= LOADED;
          cfg_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scan_seq_ctrl.sv
// Scoreboard bench for scan_seq_ctrl. Expected addresses come from a
// multiply-based model and are queued at launch. They are popped on each
// observed handshake.
module tb_scan_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid, cfg_ready;
  logic [31:0] cfg_offset, cfg_x_max, cfg_x_stride, cfg_y_max, cfg_y_stride;
  logic        start, abort, busy, done, cfg_err;
  logic        addr_valid, addr_ready, addr_last;
  logic [31:0] addr;

  int n_cmp = 0;
  int n_err = 0;
  logic [32:0] exp_q[$];

  always #5 clk = ~clk;

  scan_seq_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_offset(cfg_offset), .cfg_x_max(cfg_x_max), .cfg_x_stride(cfg_x_stride),
    .cfg_y_max(cfg_y_max), .cfg_y_stride(cfg_y_stride),
    .start(start), .abort(abort), .busy(busy), .done(done), .cfg_err(cfg_err),
    .addr_valid(addr_valid), .addr_ready(addr_ready),
    .addr(addr), .addr_last(addr_last)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  task automatic push_seq(input logic [31:0] off, xm, xs, ym, ys);
    logic [31:0] a;
    for (int yi = 0; yi < int'(ym); yi++)
      for (int xi = 0; xi < int'(xm); xi++) begin
        a = off + 32'(xi) * xs + 32'(yi) * ys;
        exp_q.push_back({(xi == int'(xm) - 1) && (yi == int'(ym) - 1), a});
      end
  endtask

  task automatic set_cfg(input logic [31:0] off, xm, xs, ym, ys);
    cfg_offset = off; cfg_x_max = xm; cfg_x_stride = xs;
    cfg_y_max = ym; cfg_y_stride = ys;
  endtask

  task automatic do_cfg(input logic [31:0] off, xm, xs, ym, ys);
    @(negedge clk);
    set_cfg(off, xm, xs, ym, ys);
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  // Returns at the negedge after the start edge.
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Drives ready, compares handshakes against the queue, and checks hold
  // behaviour while stalled. mode 0: ready=1; 1: 1,0,0 pattern; 2: random.
  // Exits at the negedge following the last acceptance, then checks done.
  task automatic run_seq(input int mode);
    int          cyc = 0;
    logic        stalled = 1'b0;
    logic [31:0] hold = '0;
    logic        hold_last = 1'b0;
    logic [32:0] e;
    while (exp_q.size() > 0 && cyc < 300) begin
      case (mode)
        0:       addr_ready = 1'b1;
        1:       addr_ready = (cyc % 3 == 0);
        default: addr_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      chk("valid_in_run", {31'b0, addr_valid}, 32'd1);
      if (stalled) begin
        chk("stall_addr", addr, hold);
        chk("stall_last", {31'b0, addr_last}, {31'b0, hold_last});
      end
      if (addr_valid && addr_ready) begin
        e = exp_q.pop_front();
        chk("addr", addr, e[31:0]);
        chk("last", {31'b0, addr_last}, {31'b0, e[32]});
        stalled = 1'b0;
      end else if (addr_valid) begin
        stalled   = 1'b1;
        hold      = addr;
        hold_last = addr_last;
      end
      @(negedge clk);
      cyc++;
    end
    if (exp_q.size() > 0) begin
      chk("timeout", 32'd0, 32'd1);
      exp_q.delete();
    end
    addr_ready = 1'b0;
    chk("done_pulse", {31'b0, done}, 32'd1);
    chk("busy_after", {31'b0, busy}, 32'd0);
    chk("valid_after", {31'b0, addr_valid}, 32'd0);
    @(negedge clk);
    chk("done_one_cycle", {31'b0, done}, 32'd0);
    chk("cfg_ready_after", {31'b0, cfg_ready}, 32'd1);
  endtask

  // Accept n addresses with ready held high.
  task automatic accept_n(input int n);
    logic [32:0] e;
    addr_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      #1;
      chk("pre_valid", {31'b0, addr_valid}, 32'd1);
      e = exp_q.pop_front();
      chk("pre_addr", addr, e[31:0]);
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; start = 1'b0; abort = 1'b0; addr_ready = 1'b0;
    set_cfg('0, '0, '0, '0, '0);
    repeat (2) @(negedge clk);
    chk("rst_cfg_ready", {31'b0, cfg_ready}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_valid", {31'b0, addr_valid}, 32'd0);
    chk("rst_addr", addr, 32'd0);
    rst = 1'b0;

    // start with no config
    pulse_start();
    chk("nocfg_err", {31'b0, cfg_err}, 32'd1);
    chk("nocfg_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    chk("nocfg_err_pulse", {31'b0, cfg_err}, 32'd0);

    // basic scan, ready always high
    do_cfg(32'h100, 3, 4, 2, 32'h40);
    push_seq(32'h100, 3, 4, 2, 32'h40);
    pulse_start();
    chk("run_busy", {31'b0, busy}, 32'd1);
    chk("run_cfg_ready", {31'b0, cfg_ready}, 32'd0);
    run_seq(0);

    // same config relaunched with a stalling consumer
    push_seq(32'h100, 3, 4, 2, 32'h40);
    pulse_start();
    run_seq(1);

    // zero extent refused, state stays LOADED
    do_cfg(32'h100, 0, 4, 2, 32'h40);
    pulse_start();
    chk("zext_err", {31'b0, cfg_err}, 32'd1);
    chk("zext_busy", {31'b0, busy}, 32'd0);
    chk("zext_cfg_ready", {31'b0, cfg_ready}, 32'd1);

    // single address at top of space, then a wrapping scan
    do_cfg(32'hFFFF_FFFC, 1, 0, 1, 0);
    push_seq(32'hFFFF_FFFC, 1, 0, 1, 0);
    pulse_start();
    run_seq(0);
    do_cfg(32'hFFFF_FFFC, 2, 8, 1, 8);
    push_seq(32'hFFFF_FFFC, 2, 8, 1, 8);
    pulse_start();
    run_seq(2);

    // cfg and start together: launch uses old config, new one applies next
    @(negedge clk);
    set_cfg(32'h200, 2, 1, 2, 32'h10);
    cfg_valid = 1'b1; start = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0; start = 1'b0;
    push_seq(32'hFFFF_FFFC, 2, 8, 1, 8);
    run_seq(0);
    push_seq(32'h200, 2, 1, 2, 32'h10);
    pulse_start();
    run_seq(2);

    // abort after two accepted addresses, then relaunch from offset
    do_cfg(32'h100, 3, 4, 2, 32'h40);
    push_seq(32'h100, 3, 4, 2, 32'h40);
    pulse_start();
    accept_n(2);
    addr_ready = 1'b0; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_valid", {31'b0, addr_valid}, 32'd0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_cfg_ready", {31'b0, cfg_ready}, 32'd1);
    @(negedge clk);
    chk("abort_done2", {31'b0, done}, 32'd0);
    exp_q.delete();
    push_seq(32'h100, 3, 4, 2, 32'h40);
    pulse_start();
    run_seq(2);

    // a few random small jobs
    for (int j = 0; j < 3; j++) begin
      logic [31:0] o, xm, xs, ym, ys;
      o = $urandom; xm = $urandom_range(1, 4); ym = $urandom_range(1, 3);
      xs = $urandom; ys = $urandom;
      do_cfg(o, xm, xs, ym, ys);
      push_seq(o, xm, xs, ym, ys);
      pulse_start();
      run_seq(2);
    end

    // reset mid-run, then start must be refused
    do_cfg(32'h100, 3, 4, 2, 32'h40);
    push_seq(32'h100, 3, 4, 2, 32'h40);
    pulse_start();
    accept_n(2);
    addr_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    chk("mrst_valid", {31'b0, addr_valid}, 32'd0);
    chk("mrst_busy", {31'b0, busy}, 32'd0);
    chk("mrst_last", {31'b0, addr_last}, 32'd0);
    chk("mrst_addr", addr, 32'd0);
    chk("mrst_cfg_ready", {31'b0, cfg_ready}, 32'd1);
    pulse_start();
    chk("mrst_start_err", {31'b0, cfg_err}, 32'd1);
    chk("mrst_start_busy", {31'b0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
